hazard_fwd_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipeline. It replaces the purely combinational forwarding selector. It generates per-operand forwarding selects for both the EX-stage ALU muxes and the ID-stage branch comparator, and detects load-use and branch-data hazards. It holds the front end for a programmable number of cycles through a stall counter and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_fwd_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: per-operand forwarding
// selects for the EX ALU and ID branch comparator, plus a programmable stall down-counter.
module hazard_fwd_ctrl #(
   parameter int REG_AW        = 5,
   parameter int NUM_SRC       = 2,
   parameter int LOAD_STALL    = 1,
   parameter int BR_ALU_STALL  = 1,
   parameter int BR_LOAD_STALL = 2,
   parameter int CNT_W         = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_SRC*REG_AW-1:0]   id_src,
   input  logic [NUM_SRC-1:0]          id_src_used,
   input  logic                        id_branch,
   input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
   input  logic                        ex_regwrite,
   input  logic                        ex_memread,
   input  logic [REG_AW-1:0]           ex_wreg,
   input  logic                        mem_regwrite,
   input  logic [REG_AW-1:0]           mem_wreg,
   input  logic                        wb_regwrite,
   input  logic [REG_AW-1:0]           wb_wreg,
   input  logic                        perf_clr,
   output logic [2*NUM_SRC-1:0]        ex_fwd_sel,
   output logic [2*NUM_SRC-1:0]        id_fwd_sel,
   output logic                        stall,
   output logic                        bubble,
   output logic [2:0]                  stall_cnt,
   output logic [CNT_W-1:0]            stall_cycles
);

   localparam logic [2:0] N_LOAD    = 3'(LOAD_STALL);
   localparam logic [2:0] N_BR_ALU  = 3'(BR_ALU_STALL);
   localparam logic [2:0] N_BR_LOAD = 3'(BR_LOAD_STALL);
   localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

   logic       match;
   logic [2:0] need_n;
   logic       cnt_idle;
   logic       detect_stall;

   // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
   function automatic logic [1:0] fwd_pick(
      input logic [REG_AW-1:0] src,
      input logic              m_we,
      input logic [REG_AW-1:0] m_reg,
      input logic              w_we,
      input logic [REG_AW-1:0] w_reg
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_reg != '0) && (m_reg == src))
         sel = 2'b10;
      else if (w_we && (w_reg != '0) && (w_reg == src))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      ex_fwd_sel = '0;
      id_fwd_sel = '0;
      match      = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         ex_fwd_sel[2*k +: 2] = fwd_pick(ex_src[k*REG_AW +: REG_AW],
                                         mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
         id_fwd_sel[2*k +: 2] = fwd_pick(id_src[k*REG_AW +: REG_AW],
                                         mem_regwrite, mem_wreg, wb_regwrite, wb_wreg);
         if (id_src_used[k] && (ex_wreg != '0) && (ex_wreg == id_src[k*REG_AW +: REG_AW]))
            match = 1'b1;
      end
   end

   always_comb begin
      need_n = 3'd0;
      if (ex_regwrite && match) begin
         if (ex_memread && id_branch)
            need_n = N_BR_LOAD;
         else if (ex_memread)
            need_n = N_LOAD;
         else if (id_branch)
            need_n = N_BR_ALU;
      end
   end

   // Detection is ignored while counting: ID holds the same instruction.
   assign cnt_idle     = (stall_cnt == 3'd0);
   assign detect_stall = cnt_idle && (need_n != 3'd0);
   assign stall        = detect_stall || !cnt_idle;
   assign bubble       = stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= 3'd0;
      else if (!cnt_idle)
         stall_cnt <= stall_cnt - 3'd1;
      else if (detect_stall)
         stall_cnt <= need_n - 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (perf_clr)
         stall_cycles <= '0;
      else if (stall && (stall_cycles != '1))
         stall_cycles <= stall_cycles + PERF_ONE;
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: a default instance plus a second instance
// with long branch-load stalls and a narrow performance counter for saturation.
module tb_hazard_fwd_ctrl;

   localparam int AW = 5;
   localparam int NS = 2;

   typedef struct packed {
      logic [3:0]  exf;
      logic [3:0]  idf;
      logic        st;
      logic        bb;
      logic [2:0]  cnt;
      logic [15:0] cyc;
   } obs_t;

   logic              clk;
   logic              rst_n;
   logic [NS*AW-1:0]  id_src;
   logic [NS-1:0]     id_src_used;
   logic              id_branch;
   logic [NS*AW-1:0]  ex_src;
   logic              ex_regwrite;
   logic              ex_memread;
   logic [AW-1:0]     ex_wreg;
   logic              mem_regwrite;
   logic [AW-1:0]     mem_wreg;
   logic              wb_regwrite;
   logic [AW-1:0]     wb_wreg;
   logic              perf_clr;

   logic [3:0]  ex_fwd_sel1, id_fwd_sel1, ex_fwd_sel2, id_fwd_sel2;
   logic        stall1, bubble1, stall2, bubble2;
   logic [2:0]  stall_cnt1, stall_cnt2;
   logic [15:0] stall_cycles1;
   logic [3:0]  stall_cycles2;

   int   n_cmp = 0;
   int   n_bad = 0;
   obs_t sb[$];

   hazard_fwd_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
      .id_branch(id_branch), .ex_src(ex_src), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_wreg(ex_wreg), .mem_regwrite(mem_regwrite),
      .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
      .perf_clr(perf_clr), .ex_fwd_sel(ex_fwd_sel1), .id_fwd_sel(id_fwd_sel1),
      .stall(stall1), .bubble(bubble1), .stall_cnt(stall_cnt1), .stall_cycles(stall_cycles1)
   );

   hazard_fwd_ctrl #(.LOAD_STALL(3), .BR_ALU_STALL(0), .BR_LOAD_STALL(5), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
      .id_branch(id_branch), .ex_src(ex_src), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_wreg(ex_wreg), .mem_regwrite(mem_regwrite),
      .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
      .perf_clr(perf_clr), .ex_fwd_sel(ex_fwd_sel2), .id_fwd_sel(id_fwd_sel2),
      .stall(stall2), .bubble(bubble2), .stall_cnt(stall_cnt2), .stall_cycles(stall_cycles2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t obs1();
      return {ex_fwd_sel1, id_fwd_sel1, stall1, bubble1, stall_cnt1, stall_cycles1};
   endfunction

   function automatic obs_t obs2();
      return {ex_fwd_sel2, id_fwd_sel2, stall2, bubble2, stall_cnt2, 12'd0, stall_cycles2};
   endfunction

   function automatic obs_t mk(input logic [3:0] exf, input logic [3:0] idf, input logic st,
                               input logic [2:0] cnt, input logic [15:0] cyc);
      return {exf, idf, st, st, cnt, cyc};
   endfunction

   task automatic quiet();
      id_src = '0; id_src_used = '0; id_branch = 1'b0; ex_src = '0;
      ex_regwrite = 1'b0; ex_memread = 1'b0; ex_wreg = '0;
      mem_regwrite = 1'b0; mem_wreg = '0; wb_regwrite = 1'b0; wb_wreg = '0;
      perf_clr = 1'b0;
   endtask

   // Called one time unit after a rising edge; returns at the same phase.
   task automatic do_reset();
      quiet();
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      quiet();
      rst_n = 1'b0;
      #2;
      sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd0));
      got = obs1(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_dut: got %b required %b", got, exp); end
      sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd0));
      got = obs2(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_dut2: got %b required %b", got, exp); end
      // stall stays combinational while reset is held
      ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd3;
      id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
      #1;
      sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd0, 16'd0));
      got = obs1(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_detect: got %b required %b", got, exp); end
      quiet();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_forwarding();
      obs_t got, exp;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         quiet();
         case (i)
            0: begin
               mem_regwrite = 1'b1; mem_wreg = 5'd5; wb_regwrite = 1'b1; wb_wreg = 5'd7;
               ex_src = {5'd7, 5'd5}; id_src = {5'd5, 5'd7};
               sb.push_back(mk(4'b0110, 4'b1001, 1'b0, 3'd0, 16'd0));
            end
            1: begin
               mem_regwrite = 1'b1; mem_wreg = 5'd5; wb_regwrite = 1'b1; wb_wreg = 5'd5;
               ex_src = {5'd5, 5'd5}; id_src = {5'd5, 5'd9};
               sb.push_back(mk(4'b1010, 4'b1000, 1'b0, 3'd0, 16'd0));
            end
            2: begin
               mem_regwrite = 1'b0; mem_wreg = 5'd5; wb_regwrite = 1'b1; wb_wreg = 5'd5;
               ex_src = {5'd5, 5'd5}; id_src = {5'd3, 5'd5};
               sb.push_back(mk(4'b0101, 4'b0001, 1'b0, 3'd0, 16'd0));
            end
            3: begin
               mem_regwrite = 1'b1; mem_wreg = 5'd0; wb_regwrite = 1'b1; wb_wreg = 5'd0;
               ex_src = {5'd0, 5'd0}; id_src = {5'd0, 5'd0};
               sb.push_back(mk(4'b0000, 4'b0000, 1'b0, 3'd0, 16'd0));
            end
            default: begin
               mem_regwrite = 1'b1; mem_wreg = 5'd6; wb_regwrite = 1'b0; wb_wreg = 5'd6;
               ex_src = {5'd6, 5'd1}; id_src = {5'd1, 5'd6};
               sb.push_back(mk(4'b1000, 4'b0010, 1'b0, 3'd0, 16'd0));
            end
         endcase
         @(negedge clk);
         got = obs1(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL fwd[%0d]: got %b required %b", i, got, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      obs_t got, exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         quiet();
         case (i)
            0: begin
               ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd3;
               id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
               sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd0, 16'd0));
            end
            1: begin
               mem_regwrite = 1'b1; mem_wreg = 5'd3;
               id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
               sb.push_back(mk(4'b0, 4'b0010, 1'b0, 3'd0, 16'd1));
            end
            default: sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd1));
         endcase
         @(negedge clk);
         got = obs1(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL load_use[%0d]: got %b required %b", i, got, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_load();
      obs_t got, exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         quiet();
         id_branch = 1'b1; id_src = {5'd4, 5'd0}; id_src_used = 2'b10;
         if (i < 2) begin
            ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd4;
         end else begin
            wb_regwrite = 1'b1; wb_wreg = 5'd4;
         end
         case (i)
            0: sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd0, 16'd0));
            1: sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd1, 16'd1));
            default: sb.push_back(mk(4'b0, 4'b0100, 1'b0, 3'd0, 16'd2));
         endcase
         @(negedge clk);
         got = obs1(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL branch_load[%0d]: got %b required %b", i, got, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_alu();
      obs_t got, exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         quiet();
         id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
         case (i)
            0: begin
               ex_regwrite = 1'b1; ex_wreg = 5'd9; id_branch = 1'b1;
               sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd0, 16'd0));
            end
            1: begin
               mem_regwrite = 1'b1; mem_wreg = 5'd9; id_branch = 1'b1;
               sb.push_back(mk(4'b0, 4'b0010, 1'b0, 3'd0, 16'd1));
            end
            default: begin
               ex_regwrite = 1'b1; ex_wreg = 5'd9;
               sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd1));
            end
         endcase
         @(negedge clk);
         got = obs1(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL branch_alu[%0d]: got %b required %b", i, got, exp); end
         if (i == 0) begin
            // BR_ALU_STALL=0 instance must not stall on the same pattern
            sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd0));
            got = obs2(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL branch_alu_zero: got %b required %b", got, exp); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_masked();
      obs_t got, exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         quiet();
         case (i)
            0: begin
               ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd0; id_branch = 1'b1;
               id_src_used = 2'b11; mem_regwrite = 1'b1; mem_wreg = 5'd0;
               sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd0));
            end
            1: begin
               ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd6; id_branch = 1'b1;
               id_src = {5'd0, 5'd6}; id_src_used = 2'b10;
               ex_src = {5'd6, 5'd6}; wb_regwrite = 1'b1; wb_wreg = 5'd6;
               sb.push_back(mk(4'b0101, 4'b0001, 1'b0, 3'd0, 16'd0));
            end
            default: begin
               ex_memread = 1'b1; ex_wreg = 5'd6; id_branch = 1'b1;
               id_src = {5'd0, 5'd6}; id_src_used = 2'b01;
               sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd0));
            end
         endcase
         @(negedge clk);
         got = obs1(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL masked[%0d]: got %b required %b", i, got, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_stall();
      obs_t got, exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         quiet();
         ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd4; id_branch = 1'b1;
         id_src = {5'd0, 5'd4}; id_src_used = 2'b01;
         case (i)
            0: sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd0, 16'd0));
            1: sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd4, 16'd1));
            default: sb.push_back(mk(4'b0, 4'b0, 1'b1, 3'd3, 16'd2));
         endcase
         @(negedge clk);
         got = obs2(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL mid_stall[%0d]: got %b required %b", i, got, exp); end
         if (i < 2) begin @(posedge clk); #1; end
      end
      quiet();
      #1 rst_n = 1'b0;
      #1;
      sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd0));
      got = obs2(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL mid_stall_reset: got %b required %b", got, exp); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      sb.push_back(mk(4'b0, 4'b0, 1'b0, 3'd0, 16'd0));
      @(negedge clk);
      got = obs2(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL mid_stall_release: got %b required %b", got, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      obs_t got, exp;
      logic [2:0]  cnt_e;
      logic [15:0] cyc_e;
      do_reset();
      cyc_e = 16'd0;
      for (int i = 0; i < 21; i++) begin
         quiet();
         ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wreg = 5'd3;
         id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
         perf_clr = (i == 18);
         cnt_e = (i % 3 == 0) ? 3'd0 : ((i % 3 == 1) ? 3'd2 : 3'd1);
         sb.push_back(mk(4'b0, 4'b0, 1'b1, cnt_e, cyc_e));
         @(negedge clk);
         got = obs2(); exp = sb.pop_front(); n_cmp++;
         if (got !== exp) begin n_bad++; $display("FAIL saturate[%0d]: got %b required %b", i, got, exp); end
         if (perf_clr) cyc_e = 16'd0;
         else if (cyc_e != 16'd15) cyc_e = cyc_e + 16'd1;
         @(posedge clk); #1;
      end
      quiet();
   endtask

   initial begin
      rst_n = 1'b0;
      quiet();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_load();
      test_branch_alu();
      test_masked();
      test_reset_mid_stall();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
